seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning operand width in bits (minimum 2).
REQ-002 SHALL have parameter INSTANCE_ID, default 0, meaning an identifier with no functional effect.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  meaning A, B and C are valid this cycle.
REQ-006 SHALL have port o_ready  output  1  meaning the block can accept operands this cycle.
REQ-007 SHALL have ports A and B  input  DATAWIDTH  meaning the unsigned multiplicand and the unsigned multiplier.
REQ-008 SHALL have port C  input  DATAWIDTH  meaning the unsigned addend (a divider remainder when reconstructing a dividend).
REQ-009 SHALL have port o_valid  output  1  meaning P_out holds a completed result.
REQ-010 SHALL have port i_ready  input  1  meaning the downstream consumer accepts the result this cycle.
REQ-011 SHALL have port P_out  output  2*DATAWIDTH  meaning the registered result A*B+C.

Function
REQ-012 SHALL compute P_out = A*B + C, unsigned, exactly; the maximum (2^W-1)^2+(2^W-1) fits in 2W bits, so the block SHALL NOT produce or flag overflow.
REQ-013 SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-014 In IDLE, o_ready=1 and o_valid=0; when i_valid=1, the block SHALL capture A, B and C, load the accumulator with zero-extended C, clear the bit counter and go to BUSY.
REQ-015 In BUSY, o_ready=0 and o_valid=0; each cycle, if B_reg[count]=1 the block SHALL add A_reg shifted left by count to the accumulator, then increment count.
REQ-016 BUSY SHALL last exactly DATAWIDTH cycles; on the edge that processes count=DATAWIDTH-1 the block SHALL go to DONE.
REQ-017 o_valid SHALL rise exactly DATAWIDTH cycles after the accepting edge.
REQ-018 In DONE, o_valid=1 and o_ready=0; P_out SHALL equal the final accumulator and SHALL remain stable while i_ready=0.
REQ-019 In DONE with i_ready=1, the block SHALL go to IDLE on that edge; the next accept is possible on the following cycle, giving a minimum initiation interval of DATAWIDTH+2 cycles.
REQ-020 i_valid, A, B and C SHALL be ignored outside IDLE; the operands SHALL NOT change the in-flight computation.
REQ-021 B=0 SHALL still take the full DATAWIDTH cycles and yield P_out=C.
REQ-022 P_out outside DONE SHALL hold its last value; consumers SHALL qualify it with o_valid.

Reset
REQ-023 On rst=1 at a rising edge, the block SHALL force state=IDLE, count=0, accumulator=0, P_out=0, o_valid=0 and o_ready=1 (the IDLE value) in the next cycle.
REQ-024 rst SHALL override every other input, including mid-BUSY and DONE, and SHALL discard any in-flight result without asserting o_valid.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE, BUSY, DONE).
REQ-026 A combinational sub-module mul_step_comb SHALL perform one conditional shift-add step, taking the accumulator, A_reg, the multiplier bit and the shift amount and returning the next accumulator.
REQ-027 The counter SHALL be $clog2(DATAWIDTH)+1 bits wide; all arithmetic SHALL be 2*DATAWIDTH bits wide.

Verification (DATAWIDTH=8)
REQ-028 Basic: A=13, B=11, C=4 accepted at edge k -> o_valid rises after edge k+8 with P_out=147; o_ready is 0 during edges k+1 to k+8.
REQ-029 Maximum: A=255, B=255, C=255 -> P_out=65280, with no overflow.
REQ-030 Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid stays 1, P_out stays constant and o_ready stays 0; i_ready=1 -> IDLE on the next edge.
REQ-031 Ignored input: change A and B and pulse i_valid mid-BUSY -> the result still matches the originally captured operands.
REQ-032 Reset mid-op: assert rst at BUSY count=3 -> the next cycle shows o_valid=0, o_ready=1 and P_out=0; no stale result ever appears.
REQ-033 Divider round-trip: feed the divider outputs Q, B and R for A=200, B=7 (Q=28, R=4) -> P_out=200; a random sweep of 1000 vectors matches a reference model.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared types for the sequential shift-add multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must reach DATAWIDTH itself, hence one bit beyond the index width.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_step.sv
// One conditional shift-add step: acc + (a << shamt) when the multiplier bit is set.
module mul_step_comb #(
  parameter int DATAWIDTH = 8,
  parameter int SHW       = 3
) (
  input  logic [2*DATAWIDTH-1:0] acc_i,
  input  logic [DATAWIDTH-1:0]   a_i,
  input  logic                   bit_i,
  input  logic [SHW-1:0]         shamt_i,
  output logic [2*DATAWIDTH-1:0] acc_o
);

  logic [2*DATAWIDTH-1:0] shifted;

  always_comb begin
    shifted = {{DATAWIDTH{1'b0}}, a_i} << shamt_i;
    acc_o   = bit_i ? (acc_i + shifted) : acc_i;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiply-add P_out = A*B + C, one multiplier bit per cycle.
// Accept in IDLE, DATAWIDTH cycles in BUSY, result held in DONE until i_ready.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int INSTANCE_ID = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATAWIDTH-1:0]   A,
  input  logic [DATAWIDTH-1:0]   B,
  input  logic [DATAWIDTH-1:0]   C,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [2*DATAWIDTH-1:0] P_out
);

  localparam int CW = cnt_width(DATAWIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Identifier only; it has no functional effect.
  if (INSTANCE_ID < 0) begin : g_id_unused
  end

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [2*DATAWIDTH-1:0] acc_q, acc_d;
  logic [2*DATAWIDTH-1:0] p_q, p_d;
  logic [DATAWIDTH-1:0]   a_q, a_d;
  logic [DATAWIDTH-1:0]   b_q, b_d;
  logic [2*DATAWIDTH-1:0] acc_step;

  mul_step_comb #(
    .DATAWIDTH(DATAWIDTH),
    .SHW      (CW - 1)
  ) u_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .bit_i  (b_q[count_q[CW-2:0]]),
    .shamt_i(count_q[CW-2:0]),
    .acc_o  (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = A;
          b_d     = B;
          acc_d   = {{DATAWIDTH{1'b0}}, C};
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_step;
        count_d = count_q + ONE;
        // P_out only changes here, so it is stable through DONE and after.
        if (count_q == LAST) begin
          p_d     = acc_step;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign P_out   = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at DATAWIDTH=8: vector table, corner sequences, random sweep.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_valid = 1'b0;
  logic           i_ready = 1'b0;
  logic [W-1:0]   A = '0, B = '0, C = '0;
  logic           o_ready, o_valid;
  logic [2*W-1:0] P_out;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp;
  } vec_t;

  seq_multiplier #(.DATAWIDTH(W), .INSTANCE_ID(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .A      (A),
    .B      (B),
    .C      (C),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .P_out  (P_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [2*W-1:0] exp);
    int n = 0;
    while (!o_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
    A = a; B = b; C = c;
    i_valid = 1'b1;
    sb.push_back(exp);
    step();
    i_valid = 1'b0;
  endtask

  // lat0: edges already elapsed since the accepting edge; hold: cycles of i_ready=0 in DONE.
  task automatic finish_op(input int lat0, input int hold);
    int lat = lat0;
    logic rdy_seen = 1'b0;
    logic [2*W-1:0] p0;
    logic [2*W-1:0] exp;
    while (!o_valid && lat < 40) begin
      if (o_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
    chk("latency", lat, W);
    chk("ready_low_busy", {31'd0, rdy_seen}, 32'd0);
    if (!o_valid) return;
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
    chk("result", {16'd0, P_out}, {16'd0, exp});
    p0 = P_out;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      chk("bp_stable", {16'd0, P_out}, {16'd0, p0});
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("idle_after_accept", {30'd0, o_valid, o_ready}, 32'd1);
    chk("p_hold_idle", {16'd0, P_out}, {16'd0, p0});
  endtask

  initial begin
    vec_t vecs[9];
    logic stale;
    logic [W-1:0] ra, rb, rc;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  c: 8'd4,   exp: 16'd147};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, exp: 16'd65280};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   exp: 16'd0};
    vecs[3] = '{a: 8'd28,  b: 8'd7,   c: 8'd4,   exp: 16'd200};
    vecs[4] = '{a: 8'd200, b: 8'd0,   c: 8'd37,  exp: 16'd37};
    vecs[5] = '{a: 8'd1,   b: 8'd1,   c: 8'd0,   exp: 16'd1};
    vecs[6] = '{a: 8'd255, b: 8'd1,   c: 8'd0,   exp: 16'd255};
    vecs[7] = '{a: 8'd1,   b: 8'd255, c: 8'd255, exp: 16'd510};
    vecs[8] = '{a: 8'd128, b: 8'd128, c: 8'd0,   exp: 16'd16384};

    step();
    step();
    rst = 1'b0;
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_p", {16'd0, P_out}, 32'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);
      finish_op(0, 0);
    end

    // Backpressure in DONE.
    start_op(8'd13, 8'd11, 8'd4, 16'd147);
    finish_op(0, 5);

    // Operand changes and an i_valid pulse mid-BUSY must be ignored.
    start_op(8'd13, 8'd11, 8'd4, 16'd147);
    step();
    step();
    A = 8'd99; B = 8'd77; C = 8'd5;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    finish_op(3, 0);

    // Reset at BUSY count=3 discards the in-flight result.
    start_op(8'd250, 8'd250, 8'd9, 16'd62509);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    chk("midrst_p", {16'd0, P_out}, 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_valid) stale = 1'b1;
      step();
    end
    chk("no_stale_result", {31'd0, stale}, 32'd0);

    // Divider round-trip after reset recovery.
    start_op(8'd28, 8'd7, 8'd4, 16'd200);
    finish_op(0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = W'($urandom_range(0, 255));
      start_op(ra, rb, rc, 16'(32'(ra) * 32'(rb) + 32'(rc)));
      finish_op(0, (i % 7 == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
